// File: rtl/c157x_head_pos.sv
// Head-position and track-flush controller for the 157x drive: decodes stepper phases into
// a half-track / SD track index, tracks buffer dirtiness and issues toggle-style save/load requests.
module c157x_head_pos #(
    parameter int INIT_TRACK   = 36,
    parameter int MAX_HTRACK   = 84,
    parameter int SIDE_OFFSET  = 84,
    parameter int SETTLE_TICKS = 16000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       mtr,
    input  logic [1:0] stp,
    input  logic       side,
    input  logic       img_mounted,
    input  logic       sd_update,
    input  logic       write,
    input  logic       act,
    input  logic       fdc_busy,
    input  logic       sd_busy,
    output logic [6:0] track_num,
    output logic [7:0] track,
    output logic       tr00,
    output logic       dirty,
    output logic       save_track,
    output logic       load_req
);

    localparam int CW = $clog2(SETTLE_TICKS + 1);

    logic [1:0]    rst_sync;
    logic          rst_n_i;
    logic [1:0]    stp_old;
    logic          armed;
    logic          side_old;
    logic          mnt_old;
    logic          pend;
    logic [CW-1:0] settle_cnt;

    logic [1:0]    move;
    logic          step_in;
    logic          step_out;
    logic          stepped;
    logic          side_evt;
    logic          mount_rise;
    logic          idle;
    logic          flush;
    logic          reload;
    logic [6:0]    track_num_nxt;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_i = rst_sync[1];

    always_comb begin
        move          = stp - stp_old;
        step_in       = armed && (move == 2'd1);
        step_out      = armed && (move == 2'd3);
        stepped       = mtr && (step_in || step_out);
        side_evt      = armed && (side != side_old);
        mount_rise    = armed && img_mounted && !mnt_old;
        idle          = !write && !act && !fdc_busy && !sd_busy;
        // A clamped step still counts as motion for flushing, but not for reloading.
        flush         = dirty && (stepped || side_evt || idle);
        track_num_nxt = track_num;
        if (mtr && step_in && (track_num < 7'(MAX_HTRACK)))
            track_num_nxt = track_num + 7'd1;
        else if (mtr && step_out && (track_num != 7'd0))
            track_num_nxt = track_num - 7'd1;
        reload        = (track_num_nxt != track_num) || side_evt || mount_rise;
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            track_num  <= 7'(INIT_TRACK);
            track      <= 8'(INIT_TRACK);
            tr00       <= 1'b0;
            dirty      <= 1'b0;
            save_track <= 1'b0;
            load_req   <= 1'b0;
            settle_cnt <= '0;
            pend       <= 1'b0;
            stp_old    <= 2'd0;
            armed      <= 1'b0;
            side_old   <= 1'b0;
            mnt_old    <= 1'b0;
        end else begin
            stp_old   <= stp;
            side_old  <= side;
            mnt_old   <= img_mounted;
            armed     <= 1'b1;
            track_num <= track_num_nxt;
            // side_old keeps track one cycle behind a side change too, so a save
            // request raised by the side event still sees the outgoing track.
            track     <= {1'b0, track_num} + (side_old ? 8'(SIDE_OFFSET) : 8'd0);
            tr00      <= (track_num == 7'd0);

            if (flush) save_track <= ~save_track;

            if (mount_rise)     dirty <= 1'b0;
            else if (sd_update) dirty <= 1'b1;
            else if (flush)     dirty <= 1'b0;

            if (reload) begin
                settle_cnt <= CW'(SETTLE_TICKS);
                pend       <= 1'b1;
            end else if (settle_cnt != '0) begin
                if (ce) settle_cnt <= settle_cnt - CW'(1);
            end else if (pend) begin
                load_req <= ~load_req;
                pend     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_c157x_head_pos.sv
// Directed bench for c157x_head_pos: save/load toggles are matched against an expected-event
// queue by a monitor; positions and dirty state are checked inline by the driver.
module tb_c157x_head_pos;

    localparam int S = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       mtr;
    logic [1:0] stp;
    logic       side;
    logic       img_mounted;
    logic       sd_update;
    logic       write;
    logic       act;
    logic       fdc_busy;
    logic       sd_busy;
    logic [6:0] track_num;
    logic [7:0] track;
    logic       tr00;
    logic       dirty;
    logic       save_track;
    logic       load_req;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_stp;
    bit mon_en = 1'b0;
    logic save_prev = 1'b0;
    logic load_prev = 1'b0;
    // Entry: bit 8 = kind (0 save, 1 load), bits 7:0 = track seen when the toggle appears.
    logic [8:0] exp_q[$];

    c157x_head_pos #(
        .INIT_TRACK(36), .MAX_HTRACK(84), .SIDE_OFFSET(84), .SETTLE_TICKS(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mtr(mtr), .stp(stp), .side(side),
        .img_mounted(img_mounted), .sd_update(sd_update), .write(write), .act(act),
        .fdc_busy(fdc_busy), .sd_busy(sd_busy), .track_num(track_num), .track(track),
        .tr00(tr00), .dirty(dirty), .save_track(save_track), .load_req(load_req)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d events outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step(input int dir);
        cur_stp = (cur_stp + dir) & 3;
        stp = 2'(cur_stp);
        tick(1);
    endtask

    task automatic push_save(input int trk);
        exp_q.push_back({1'b0, 8'(trk)});
    endtask

    task automatic push_load(input int trk);
        exp_q.push_back({1'b1, 8'(trk)});
    endtask

    // scoreboard monitor
    task automatic check_evt(input logic kind);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_toggle: got kind %0d at track %0d, expected none", kind, track);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", int'(kind), int'(e[8]));
            chk(kind ? "load_track" : "save_track_pos", int'(track), int'(e[7:0]));
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (save_track !== save_prev) check_evt(1'b0);
            if (load_req !== load_prev)   check_evt(1'b1);
        end
        save_prev = save_track;
        load_prev = load_req;
    end

    initial begin
        reset_n = 1'b0; ce = 1'b1; mtr = 1'b0; stp = 2'd2; cur_stp = 2; side = 1'b0;
        img_mounted = 1'b0; sd_update = 1'b0; write = 1'b0; act = 1'b0;
        fdc_busy = 1'b0; sd_busy = 1'b0;
        tick(3);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick(5);
        chk("rst_track_num", track_num, 36);
        chk("rst_track", track, 36);
        chk("rst_tr00", tr00, 0);
        chk("rst_save", save_track, 0);
        chk("rst_load", load_req, 0);
        chk("rst_dirty", dirty, 0);

        // step in 36 -> 39, single settled load
        mtr = 1'b1;
        stp = 2'd0; cur_stp = 0;
        tick(4);
        chk("double_step_ignored", track_num, 36);
        step(1); tick(3);
        chk("step_in_37", track_num, 37);
        chk("track_37", track, 37);
        step(1); tick(3);
        chk("step_in_38", track_num, 38);
        push_load(39);
        step(1); tick(3);
        chk("step_in_39", track_num, 39);
        chk("track_39", track, 39);
        tick(S - 3);
        chk("load_not_early", load_req, 0);
        tick(1);
        chk("load_after_settle", load_req, 1);

        // step out to the stop
        for (int i = 0; i < 38; i++) step(-1);
        chk("step_out_1", track_num, 1);
        push_load(0);
        step(-1);
        chk("step_out_0", track_num, 0);
        step(-1);
        chk("clamp_0_a", track_num, 0);
        step(-1);
        chk("clamp_0_b", track_num, 0);
        tick(1);
        chk("tr00_set", tr00, 1);
        step(2);
        tick(1);
        chk("jump_ignored", track_num, 0);
        tick(S);

        // move flush while busy
        act = 1'b1;
        sd_update = 1'b1; tick(1); sd_update = 1'b0;
        chk("dirty_busy", dirty, 1);
        push_save(0);
        push_load(1);
        step(1);
        chk("move_flush_clear", dirty, 0);
        chk("move_flush_save", save_track, 1);
        chk("track_lags", track, 0);
        tick(1);
        chk("track_follows", track, 1);
        act = 1'b0;
        tick(S + 2);

        // idle flush, then coincident sd_update
        push_save(1);
        sd_update = 1'b1; tick(1); sd_update = 1'b0;
        chk("dirty_idle_set", dirty, 1);
        tick(1);
        chk("idle_flush_clear", dirty, 0);
        chk("idle_flush_save", save_track, 0);
        push_save(1);
        push_save(1);
        sd_update = 1'b1; tick(2);
        chk("flush_with_update", dirty, 1);
        sd_update = 1'b0; tick(1);
        chk("second_flush_clear", dirty, 0);
        chk("second_flush_save", save_track, 0);
        tick(2);

        // side change at 40
        push_load(40);
        for (int i = 0; i < 39; i++) step(1);
        chk("at_40", track_num, 40);
        tick(S + 3);
        act = 1'b1;
        sd_update = 1'b1; tick(1); sd_update = 1'b0;
        chk("dirty_pre_side", dirty, 1);
        push_save(40);
        push_load(124);
        side = 1'b1;
        tick(1);
        chk("side_flush_clear", dirty, 0);
        chk("side_flush_save", save_track, 1);
        chk("side_track_lags", track, 40);
        tick(1);
        chk("side_track", track, 124);
        tick(S + 3);

        // image mount beats sd_update
        sd_update = 1'b1; tick(1); sd_update = 1'b0;
        chk("dirty_pre_mount", dirty, 1);
        push_load(124);
        img_mounted = 1'b1; sd_update = 1'b1;
        tick(1);
        sd_update = 1'b0;
        chk("mount_clears_dirty", dirty, 0);
        tick(S + 3);

        chk("events_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c157x_head_pos.md
Name: c157x_head_pos

Overview:
- Head-position and track-flush controller for the 157x drive.
- Sits upstream of the SD track loader/saver.
- Converts the drive logic's stepper phase bits and side select into a half-track number and an SD track index.
- Tracks whether the current track buffer is dirty. Emits toggle-style save and load requests, which the loader (clk_sys domain) synchronises and acts on.

Parameters:
INIT_TRACK, 36, half-track loaded on reset (track 18 on a 1541).
MAX_HTRACK, 84, highest reachable half-track index.
SIDE_OFFSET, 84, added to the half-track index when side=1.
SETTLE_TICKS, 16000, ce ticks the head must be stationary before a load request is issued (1 ms at 16 MHz ce).

Ports:
clk  in  1  drive clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  drive clock enable (timebase for settle counter)
mtr  in  1  spindle motor on; stepping honoured only when 1
stp  in  2  stepper phase from drive logic
side  in  1  head/side select
img_mounted  in  1  image mount strobe (level, rising edge significant)
sd_update  in  1  track buffer modified this cycle (from heads)
write  in  1  head currently writing
act  in  1  drive activity LED
fdc_busy  in  1  MFM controller busy
sd_busy  in  1  SD transfer in progress (already synchronised)
track_num  out  7  current half-track 0..MAX_HTRACK
track  out  8  SD track index = track_num + (side ? SIDE_OFFSET : 0)
tr00  out  1  track_num == 0
dirty  out  1  buffer holds unsaved data
save_track  out  1  toggles once per flush request
load_req  out  1  toggles once per settled position change

Behaviour:
- Reset (async assert, sync release) sets the outputs as follows:
  - track_num=INIT_TRACK; track=INIT_TRACK.
  - tr00=0, dirty=0, save_track=0, load_req=0.
  - Settle counter=0; stp_old=0; armed=0.
  - Any pending flush is discarded.
- Arming: in the first clock after reset release, stp_old<=stp and armed<=1. No move is evaluated in that cycle.
- Step decode (armed only): move = stp − stp_old, mod 4. stp_old updates every cycle regardless of mtr.
  - move=1: step in. track_num+1 if mtr and track_num<MAX_HTRACK, else hold.
  - move=3: step out. track_num−1 if mtr and track_num>0, else hold.
  - move=0 or 2: no motion (2 is an illegal double step and is ignored).
- Side change: side_old is registered each cycle. side≠side_old is a side event and is independent of mtr.
- track and tr00 are registered from track_num and side. Latency is 1 cycle after a track_num update.
- Dirty flag:
  - Set on sd_update.
  - Cleared on a rising edge of img_mounted. The mount clear has priority over everything, including sd_update.
  - A flush clears dirty, but an sd_update in the same cycle keeps dirty=1.
- Flush on move: a step (move=1 or 3 with mtr=1, even when clamped at a limit) or a side event, while dirty=1, toggles save_track and clears dirty in that cycle.
  - The loader sampling track when it sees the toggle still observes the old track, because track lags by one cycle.
- Idle flush: dirty && !write && !act && !fdc_busy && !sd_busy toggles save_track and clears dirty.
  - Only one toggle per cycle.
  - A move flush and an idle flush in the same cycle produce a single toggle.
- Settle/load:
  - Any change of track_num or a side event reloads the settle counter with SETTLE_TICKS and sets pend=1.
  - The counter decrements on ce while nonzero.
  - When the counter is 0 and pend=1, load_req toggles once and pend clears.
  - A new motion during countdown restarts the count, so back-to-back steps produce exactly one load_req.
  - img_mounted rising also sets pend and reloads the counter, forcing a reload of the current track.
- Counter is clog2(SETTLE_TICKS+1) bits; it never underflows.
- Reset mid-countdown: pend and the counter clear; no load_req is issued.

Test Plan:
1. Release reset with stp=2 → no movement; track_num=36, track=36, tr00=0, save_track=0, load_req=0.
2. mtr=1, stp sequence 0→1→2→3 (one change per 4 clk) → track_num 37,38,39. Then, after SETTLE_TICKS ce, load_req toggles exactly once.
3. Step out from track_num=1 three times → track_num 0, 0, 0; tr00=1. Then stp jump 0→2 → no motion.
4. Pulse sd_update with act=1, then step in → save_track toggles in the step cycle with track still showing the old value for 1 cycle; dirty=0.
5. Pulse sd_update with write/act/fdc_busy/sd_busy all 0 → save_track toggles on the next clk. sd_update coincident with the flush → dirty stays 1 and a second toggle follows.
6. side 0→1 at track_num=40 with dirty=1 → one save_track toggle, track=124, then one load_req after settle. img_mounted rise with sd_update same cycle → dirty=0.
